// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider writing quotient to Lo and remainder to Hi.
// Define DIV_SIGNED_EN for two's-complement signed division; unsigned otherwise.
module div_unit (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic [31:0] DivA,
    input  logic [31:0] DivB,
    input  logic        DivControl,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  count;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] b_mag;

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] rem_shift;
    logic [31:0] rem_sub;
    logic        fits;
    logic [31:0] q_final;
    logic [31:0] r_final;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign a_abs   = DivA[31] ? (~DivA + 32'd1) : DivA;
    assign b_abs   = DivB[31] ? (~DivB + 32'd1) : DivB;
    assign q_final = neg_q ? (~quo + 32'd1) : quo;
    assign r_final = neg_r ? (~rem + 32'd1) : rem;
`else
    assign a_abs   = DivA;
    assign b_abs   = DivB;
    assign q_final = quo;
    assign r_final = rem;
`endif

    // The partial remainder is always below |B| once restored, so only the
    // shifted value needs the 33rd bit; the subtraction result fits in 32.
    assign rem_shift = {rem, quo[31]};
    assign fits      = (rem_shift >= {1'b0, b_mag});
    assign rem_sub   = rem_shift[31:0] - b_mag;

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state   <= IDLE;
            count   <= 5'd0;
            rem     <= 32'd0;
            quo     <= 32'd0;
            b_mag   <= 32'd0;
            Hi      <= 32'd0;
            Lo      <= 32'd0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (DivControl) begin
                        if (DivB == 32'd0) begin
                            DivZero <= 1'b1;
                            Done    <= 1'b1;
                        end else begin
                            quo     <= a_abs;
                            rem     <= 32'd0;
                            count   <= 5'd0;
                            b_mag   <= b_abs;
                            DivZero <= 1'b0;
`ifdef DIV_SIGNED_EN
                            neg_q   <= DivA[31] ^ DivB[31];
                            neg_r   <= DivA[31];
`endif
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= fits ? rem_sub : rem_shift[31:0];
                    quo   <= {quo[30:0], fits};
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Hi    <= r_final;
                    Lo    <= q_final;
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected Hi/Lo/DivZero,
// a monitor pops and compares on every Done pulse.
module tb_div_unit;

    logic        Clk;
    logic        ResetN;
    logic [31:0] DivA;
    logic [31:0] DivB;
    logic        DivControl;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    div_unit dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .DivA       (DivA),
        .DivB       (DivB),
        .DivControl (DivControl),
        .Hi         (Hi),
        .Lo         (Lo),
        .Busy       (Busy),
        .Done       (Done),
        .DivZero    (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (Done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL unexpected_done: got Lo=0x%08h Hi=0x%08h, expected no Done", Lo, Hi);
                end else begin
                    e = sb.pop_front();
                    check_output("lo", Lo, e.lo);
                    check_output("hi", Hi, e.hi);
                    check_output("divzero", {31'd0, DivZero}, {31'd0, e.dz});
                    check_output("busy_at_done", {31'd0, Busy}, 32'd0);
                end
            end
        end
    end

    // Issue one start, then count edges (accept edge = 1) until Done is seen.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] lo, input logic [31:0] hi,
                                  input logic dz, input int latency);
        int edges;
        @(negedge Clk);
        DivA       = a;
        DivB       = b;
        DivControl = 1'b1;
        sb.push_back('{lo: lo, hi: hi, dz: dz});
        edges = 0;
        do begin
            @(posedge Clk);
            #1;
            edges++;
            if (edges == 1) begin
                DivControl = 1'b0;
                check_output("busy_after_accept", {31'd0, Busy}, (latency > 1) ? 32'd1 : 32'd0);
            end
        end while (Done !== 1'b1 && edges < 100);
        check_output("done_latency", edges, latency);
    endtask

    initial begin
        int edges;
        ResetN     = 1'b0;
        DivA       = 32'd0;
        DivB       = 32'd0;
        DivControl = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_output("reset_hi", Hi, 32'd0);
        check_output("reset_lo", Lo, 32'd0);
        check_output("reset_busy", {31'd0, Busy}, 32'd0);
        check_output("reset_done", {31'd0, Done}, 32'd0);
        check_output("reset_divzero", {31'd0, DivZero}, 32'd0);
        @(negedge Clk);
        ResetN = 1'b1;

        apply_stimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
`ifdef DIV_SIGNED_EN
        apply_stimulus(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34);
        apply_stimulus(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34);
`else
        apply_stimulus(32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, 1'b0, 34);
        apply_stimulus(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 34);
`endif
        apply_stimulus(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 34);
        apply_stimulus(32'd7, 32'd9, 32'd0, 32'd7, 1'b0, 34);
        apply_stimulus(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 34);

        // Divide by zero keeps the previous 100/7 result and flags DivZero.
        apply_stimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        apply_stimulus(32'd5, 32'd0, 32'd14, 32'd2, 1'b1, 1);
        apply_stimulus(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

        // Reset in the middle of a divide clears everything.
        @(negedge Clk);
        DivA       = 32'd100;
        DivB       = 32'd7;
        DivControl = 1'b1;
        @(posedge Clk);
        #1;
        DivControl = 1'b0;
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        ResetN = 1'b0;
        #1;
        check_output("midreset_hi", Hi, 32'd0);
        check_output("midreset_lo", Lo, 32'd0);
        check_output("midreset_busy", {31'd0, Busy}, 32'd0);
        check_output("midreset_done", {31'd0, Done}, 32'd0);
        check_output("midreset_divzero", {31'd0, DivZero}, 32'd0);
        repeat (2) @(negedge Clk);
        ResetN = 1'b1;
        apply_stimulus(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 34);

        // A start strobe while busy must be ignored.
        @(negedge Clk);
        DivA       = 32'd100;
        DivB       = 32'd7;
        DivControl = 1'b1;
        sb.push_back('{lo: 32'd14, hi: 32'd2, dz: 1'b0});
        @(posedge Clk);
        #1;
        DivControl = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        DivA       = 32'd1;
        DivB       = 32'd1;
        DivControl = 1'b1;
        @(negedge Clk);
        DivControl = 1'b0;
        edges = 0;
        while (Done !== 1'b1 && edges < 100) begin
            @(posedge Clk);
            #1;
            edges++;
        end
        check_output("ignored_start_done_seen", {31'd0, Done}, 32'd1);
        repeat (40) @(posedge Clk);
        #2;
        check_output("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
